lc2k_multicycle_ctrl: RTL
=========================

// Module: lc2k_multicycle_ctrl
// PURPOSE
//  Multicycle control FSM for the LC2K core. Sequences fetch/decode/execute/mem/writeback
//  and drives PC-select/write, IR latch, ALU, memory handshake and regfile-write strobes.
//  Sits beside the PC mux and datapath; sole owner of pc_write/pc_sel, shared memory port.
// PARAMETERS
//  CNT_W         32   width of retired-instruction counter
//  MEM_WAIT_MAX  255  max cycles mem_req may wait for mem_ready before error-halt (>=1)
// PORTS
//  clk            in   1      system clock, rising edge
//  reset          in   1      asynchronous, active-high reset
//  opcode         in   3      IR[24:22], valid from DECODE onward
//  alu_eq         in   1      datapath regA==regB compare, valid in EXEC
//  mem_ready      in   1      memory done: fetch data / lw data valid, sw committed
//  mem_req        out  1      memory access request, held until mem_ready
//  mem_we         out  1      write qualifier for mem_req (sw only)
//  mem_addr_sel   out  1      0=PC, 1=ALU result
//  ir_write       out  1      latch instruction register
//  pc_write       out  1      PC load strobe
//  pc_sel         out  2      00=pc+1, 01=pc+1+offset (beq), 10=regA (jalr)
//  alu_op         out  2      00=add, 01=nor, 10=pass regA
//  alu_src_b      out  1      0=regB, 1=sign-extended offset
//  reg_write      out  1      regfile write strobe
//  reg_dst_sel    out  1      0=destReg IR[2:0], 1=regB IR[18:16]
//  reg_wdata_sel  out  2      00=ALU, 01=mem data, 10=pc+1
//  halted         out  1      sticky, core stopped
//  mem_err        out  1      sticky, memory timeout occurred
//  instr_count    out  CNT_W  retired instructions (INSTR_COUNT_EN only)
// BEHAVIOUR
//  States: FETCH, DECODE, EXEC, MEM, WB, HALT. Reset -> FETCH; all strobes 0, halted=0,
//   mem_err=0, wait counter=0, instr_count=0. Reset mid-operation aborts any access.
//  Outputs are combinational from state (+mem_ready where noted); no output while HALT.
//  FETCH: mem_req=1, mem_addr_sel=0. On mem_ready: ir_write=1, pc_write=1, pc_sel=00 -> DECODE.
//  DECODE: no strobes. halt(110) -> HALT; noop(111) -> FETCH (retires); else -> EXEC.
//  EXEC: add(000) alu_op=00,src_b=0 -> WB; nor(001) alu_op=01,src_b=0 -> WB;
//   lw(010)/sw(011) alu_op=00,src_b=1 -> MEM;
//   beq(100): pc_write=alu_eq, pc_sel=01 -> FETCH;
//   jalr(101): pc_write=1, pc_sel=10, reg_write=1, dst=1, wdata=10 -> FETCH.
//   jalr regA==regB: PC gets old regA (datapath reads before write, same edge).
//  MEM: mem_req=1, mem_addr_sel=1, mem_we=(opcode==sw). On mem_ready: sw -> FETCH, lw -> WB.
//  WB: reg_write=1; add/nor dst=0 wdata=00; lw dst=1 wdata=01 -> FETCH.
//  mem_ready outside FETCH/MEM ignored. mem_req never drops before mem_ready.
//  Wait counter: clears on state entry, +1 per cycle in FETCH/MEM without mem_ready; reaching
//   MEM_WAIT_MAX without mem_ready -> HALT, mem_err=1. mem_ready on that cycle wins (no error).
//  HALT: absorbing until reset; halted=1 from first HALT cycle.
//  Latency (mem_ready same cycle): add/nor/lw 4/5 cycles, sw 4, beq/jalr 3, noop/halt 2.
// CONFIGURATION
//  INSTR_COUNT_EN defined: instr_count increments on leaving WB, MEM(sw), EXEC(beq/jalr),
//   DECODE(noop/halt); wraps modulo 2^CNT_W; halt counts once.
//  Not defined: instr_count tied to 0, no counter flops.
// TESTING
//  add, mem_ready tied 1 -> FETCH,DECODE,EXEC,WB; reg_write in cycle 4, pc_write cycle 1 only.
//  lw, mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles, mem_we=0, then WB wdata=01.
//  beq alu_eq=1 -> EXEC pc_write=1 pc_sel=01; alu_eq=0 -> pc_write=0; both 3 cycles.
//  jalr -> EXEC pc_write=1, pc_sel=10, reg_write=1, reg_dst_sel=1, reg_wdata_sel=10.
//  MEM_WAIT_MAX=4, mem_ready=0 in FETCH -> HALT after 4 cycles, mem_err=1, halted=1.
//  reset pulse in MEM/sw -> mem_req=0 async; restart in FETCH, count 0 (INSTR_COUNT_EN).

Source files
------------

// File: rtl/lc2k_multicycle_ctrl.sv
// Multicycle control FSM for the LC2K core: fetch/decode/execute/mem/writeback sequencing.
// Optional retired-instruction counter enabled by defining INSTR_COUNT_EN.
module lc2k_multicycle_ctrl #(
    parameter int CNT_W        = 32,
    parameter int MEM_WAIT_MAX = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       opcode,
    input  logic             alu_eq,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic [1:0]       alu_op,
    output logic             alu_src_b,
    output logic             reg_write,
    output logic             reg_dst_sel,
    output logic [1:0]       reg_wdata_sel,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_NOR  = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_JALR = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;
    localparam logic [2:0] OP_NOOP = 3'b111;

    localparam int              WAIT_W    = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

    logic [2:0]        state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_phase;
    logic              timeout;

    assign mem_phase = (state == S_FETCH) || (state == S_MEM);
    // mem_ready on the final allowed cycle wins over the timeout
    assign timeout   = mem_phase && !mem_ready && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (mem_ready)    state_nxt = S_DECODE;
                else if (timeout) state_nxt = S_HALT;
            end
            S_DECODE: begin
                if (opcode == OP_HALT)      state_nxt = S_HALT;
                else if (opcode == OP_NOOP) state_nxt = S_FETCH;
                else                        state_nxt = S_EXEC;
            end
            S_EXEC: begin
                case (opcode)
                    OP_ADD, OP_NOR: state_nxt = S_WB;
                    OP_LW, OP_SW:   state_nxt = S_MEM;
                    default:        state_nxt = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ready)    state_nxt = (opcode == OP_SW) ? S_FETCH : S_WB;
                else if (timeout) state_nxt = S_HALT;
            end
            S_WB:    state_nxt = S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state || !mem_phase)
                wait_cnt <= '0;
            else if (!mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
            if (timeout)
                mem_err <= 1'b1;
        end
    end

    assign halted = (state == S_HALT);

    // Strobes are masked while reset is high so an aborted access drops immediately
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_sel        = 2'b00;
        alu_op        = 2'b00;
        alu_src_b     = 1'b0;
        reg_write     = 1'b0;
        reg_dst_sel   = 1'b0;
        reg_wdata_sel = 2'b00;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_EXEC: begin
                    case (opcode)
                        OP_NOR: alu_op = 2'b01;
                        OP_LW, OP_SW: alu_src_b = 1'b1;
                        OP_BEQ: begin
                            pc_write = alu_eq;
                            pc_sel   = 2'b01;
                        end
                        OP_JALR: begin
                            pc_write      = 1'b1;
                            pc_sel        = 2'b10;
                            reg_write     = 1'b1;
                            reg_dst_sel   = 1'b1;
                            reg_wdata_sel = 2'b10;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (opcode == OP_SW);
                end
                S_WB: begin
                    reg_write = 1'b1;
                    if (opcode == OP_LW) begin
                        reg_dst_sel   = 1'b1;
                        reg_wdata_sel = 2'b01;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef INSTR_COUNT_EN
    logic retire;
    assign retire = (state == S_WB)
                 || (state == S_MEM && mem_ready && opcode == OP_SW)
                 || (state == S_EXEC && (opcode == OP_BEQ || opcode == OP_JALR))
                 || (state == S_DECODE && (opcode == OP_HALT || opcode == OP_NOOP));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       instr_count <= '0;
        else if (retire) instr_count <= instr_count + 1'b1;
    end
`else
    assign instr_count = '0;
`endif

endmodule
